// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave receiver for fixed-length frames.
// Pins are synchronized into CLOCK_50; sclk/ss edges are detected one flop later.
// A frame with exactly WORD_BITS sclk rising edges updates word_out.
// Any other bit count produces a frame_err pulse instead.
// miso replays the previously received word, MSB first.
//
// Handshake: word_valid and frame_err are single-cycle, mutually exclusive
// strobes with no back-pressure. word_out and rx_count are valid in the same
// cycle as word_valid and hold until the next good frame.
module spi_frame_rx #(
   parameter int WORD_BITS   = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 CLOCK_50,
   input  logic                 reset_n,
   input  logic                 sclk,
   input  logic                 ss,
   input  logic                 mosi,
   output logic                 miso,
   output logic [WORD_BITS-1:0] word_out,
   output logic                 word_valid,
   output logic                 frame_err,
   output logic [7:0]           rx_count,
   output logic [1:0]           state_dbg
);

   typedef enum logic [1:0] {
      WAIT_IDLE = 2'd0,
      IDLE      = 2'd1,
      ACTIVE    = 2'd2
   } state_t;

   localparam logic [5:0] WORD_CNT = 6'(WORD_BITS);
   localparam logic [5:0] CNT_MAX  = 6'd63;

   // synchronizers, edge-detect delay flops and post-reset priming chain
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sclk_dly_q, ss_dly_q;
   // prime_q fills with ones after reset; WAIT_IDLE only trusts ss once the
   // reset value of the ss synchronizer has been flushed by the real pin.
   logic [SYNC_STAGES:0]   prime_q, prime_d;

   state_t               state_q, state_d;
   logic [5:0]           bit_cnt_q, bit_cnt_d;
   logic [WORD_BITS-1:0] rx_q, rx_d;
   logic [WORD_BITS-1:0] tx_q, tx_d;
   logic [WORD_BITS-1:0] word_out_q, word_out_d;
   logic                 word_valid_q, word_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic [7:0]           rx_count_q, rx_count_d;

   logic sclk_s, ss_s, mosi_s, primed;
   logic sclk_rise, sclk_fall, ss_rise, ss_fall;

   // shift each pin into its synchronizer chain
   always_comb begin
      sclk_sync_d = (sclk_sync_q << 1) | SYNC_STAGES'(sclk);
      ss_sync_d   = (ss_sync_q << 1) | SYNC_STAGES'(ss);
      mosi_sync_d = (mosi_sync_q << 1) | SYNC_STAGES'(mosi);
      prime_d     = (prime_q << 1) | (SYNC_STAGES + 1)'(1);
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign primed    = prime_q[SYNC_STAGES];
   assign sclk_rise = sclk_s & ~sclk_dly_q;
   assign sclk_fall = ~sclk_s & sclk_dly_q;
   assign ss_rise   = ss_s & ~ss_dly_q;
   assign ss_fall   = ~ss_s & ss_dly_q;

   // frame FSM, shift registers and result registers; an ss edge wins over sclk
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      rx_d         = rx_q;
      tx_d         = tx_q;
      word_out_d   = word_out_q;
      rx_count_d   = rx_count_q;
      word_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      case (state_q)
         WAIT_IDLE: begin
            if (primed && ss_s) state_d = IDLE;
         end
         IDLE: begin
            if (ss_fall) begin
               state_d   = ACTIVE;
               bit_cnt_d = 6'd0;
               rx_d      = '0;
               tx_d      = word_out_q;
            end
         end
         ACTIVE: begin
            if (ss_rise) begin
               state_d = IDLE;
               if (bit_cnt_q == WORD_CNT) begin
                  word_out_d   = rx_q;
                  word_valid_d = 1'b1;
                  rx_count_d   = rx_count_q + 8'd1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end else begin
               if (sclk_rise) begin
                  rx_d = {rx_q[WORD_BITS-2:0], mosi_s};
                  if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + 6'd1;
               end
               if (sclk_fall) tx_d = {tx_q[WORD_BITS-2:0], 1'b0};
            end
         end
         default: state_d = WAIT_IDLE;
      endcase
   end

   // all state registers; ss synchronizer resets high so no false ss fall
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync_q  <= '0;
         ss_sync_q    <= '1;
         mosi_sync_q  <= '0;
         sclk_dly_q   <= 1'b0;
         ss_dly_q     <= 1'b1;
         prime_q      <= '0;
         state_q      <= WAIT_IDLE;
         bit_cnt_q    <= 6'd0;
         rx_q         <= '0;
         tx_q         <= '0;
         word_out_q   <= '0;
         word_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         rx_count_q   <= 8'd0;
      end else begin
         sclk_sync_q  <= sclk_sync_d;
         ss_sync_q    <= ss_sync_d;
         mosi_sync_q  <= mosi_sync_d;
         sclk_dly_q   <= sclk_s;
         ss_dly_q     <= ss_s;
         prime_q      <= prime_d;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         rx_q         <= rx_d;
         tx_q         <= tx_d;
         word_out_q   <= word_out_d;
         word_valid_q <= word_valid_d;
         frame_err_q  <= frame_err_d;
         rx_count_q   <= rx_count_d;
      end
   end

   assign miso       = (state_q == ACTIVE) & tx_q[WORD_BITS-1];
   assign word_out   = word_out_q;
   assign word_valid = word_valid_q;
   assign frame_err  = frame_err_q;
   assign rx_count   = rx_count_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Bench for spi_frame_rx: randomized SPI frames driven at pin level; a frame-level
// reference model pushes expected strobes into a queue that a monitor pops.
module tb_spi_frame_rx;

   localparam int W    = 32;
   localparam int SYNC = 2;

   logic          CLOCK_50 = 1'b0;
   logic          reset_n;
   logic          sclk;
   logic          ss;
   logic          mosi;
   logic          miso;
   logic [W-1:0]  word_out;
   logic          word_valid;
   logic          frame_err;
   logic [7:0]    rx_count;
   logic [1:0]    state_dbg;

   spi_frame_rx #(.WORD_BITS(W), .SYNC_STAGES(SYNC)) dut (
      .CLOCK_50   (CLOCK_50),
      .reset_n    (reset_n),
      .sclk       (sclk),
      .ss         (ss),
      .mosi       (mosi),
      .miso       (miso),
      .word_out   (word_out),
      .word_valid (word_valid),
      .frame_err  (frame_err),
      .rx_count   (rx_count),
      .state_dbg  (state_dbg)
   );

   // clock / watchdog
   always #10 CLOCK_50 = ~CLOCK_50;

   initial begin
      #4ms;
      $display("FAIL watchdog: simulation did not complete within 4 ms");
      $fatal(1);
   end

   int n_checks = 0;
   int n_pass = 0;
   int pulses_seen = 0;

   // expected strobe record: {is_err, rx_count, word_out}
   logic [40:0] exp_q[$];
   logic [W-1:0] m_word;
   logic [7:0]   m_count;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // scoreboard monitor
   always @(negedge CLOCK_50) begin : monitor
      logic [40:0] e;
      if (reset_n === 1'b1 && (word_valid || frame_err)) begin
         pulses_seen++;
         chk("pulse_exclusive", {63'd0, word_valid & frame_err}, 64'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {62'd0, word_valid, frame_err}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("pulse_kind_err", {63'd0, frame_err}, {63'd0, e[40]});
            chk("word_out", {32'd0, word_out}, {32'd0, e[31:0]});
            chk("rx_count", {56'd0, rx_count}, {56'd0, e[39:32]});
         end
      end
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   task automatic send_bit(input logic b, input int half, output logic m);
      mosi = b;
      tick(half);
      m = miso;
      sclk = 1'b1;
      tick(half);
      sclk = 1'b0;
   endtask

   task automatic run_frame(input int n, input logic [127:0] bits, input int half, input bit coincide);
      logic [W-1:0] miso_cap;
      logic [W-1:0] old_word;
      logic m;
      int start;
      int k;
      old_word = m_word;
      miso_cap = '0;
      ss = 1'b0;
      tick(half);
      for (int i = 0; i < n; i++) begin
         send_bit(bits[n-1-i], half, m);
         if (i < W) miso_cap[W-1-i] = m;
      end
      mosi = 1'b1;
      tick(half);
      // reference model: only an exact-length frame is a good word
      if (n == W) begin
         m_count = m_count + 8'd1;
         m_word  = bits[W-1:0];
         exp_q.push_back({1'b0, m_count, m_word});
      end else begin
         exp_q.push_back({1'b1, m_count, m_word});
      end
      start = pulses_seen;
      if (coincide) sclk = 1'b1;
      ss = 1'b1;
      k = 0;
      while (pulses_seen == start && k < 12) begin
         tick(1);
         k++;
      end
      chk("pulse_latency_in_range", {63'd0, (k >= SYNC && k <= SYNC + 2)}, 64'd1);
      tick(half);
      sclk = 1'b0;
      mosi = 1'b0;
      tick(8);
      chk("miso_idle", {63'd0, miso}, 64'd0);
      if (n == W) chk("miso_stream", {32'd0, miso_cap}, {32'd0, old_word});
   endtask

   // stimulus
   initial begin
      logic m;
      int n;
      reset_n = 1'b0;
      sclk    = 1'b0;
      ss      = 1'b1;
      mosi    = 1'b0;
      m_word  = '0;
      m_count = 8'd0;
      tick(3);
      chk("reset_word_out", {32'd0, word_out}, 64'd0);
      chk("reset_rx_count", {56'd0, rx_count}, 64'd0);
      chk("reset_word_valid", {63'd0, word_valid}, 64'd0);
      chk("reset_frame_err", {63'd0, frame_err}, 64'd0);
      chk("reset_miso", {63'd0, miso}, 64'd0);
      reset_n = 1'b1;
      tick(10);

      // directed good frames near 2 MHz sclk
      run_frame(32, 128'hDEADBEEF, 13, 1'b0);
      chk("rx_count_first", {56'd0, rx_count}, 64'd1);
      run_frame(32, 128'h12345678, 13, 1'b0);
      chk("word_out_second", {32'd0, word_out}, 64'h12345678);

      // wrong lengths: short, long, empty, saturating
      run_frame(31, rand128(), 4, 1'b0);
      run_frame(33, rand128(), 4, 1'b0);
      chk("word_out_after_errs", {32'd0, word_out}, 64'h12345678);
      chk("rx_count_after_errs", {56'd0, rx_count}, 64'd2);
      run_frame(0, 128'd0, 4, 1'b0);
      run_frame(70, rand128(), 3, 1'b0);
      run_frame(96, rand128(), 3, 1'b0);

      // randomized mix of good and bad frames
      for (int f = 0; f < 20; f++) begin
         n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : W;
         run_frame(n, rand128(), $urandom_range(3, 6), 1'b0);
      end

      // reset in the middle of a frame, then finish the frame
      ss = 1'b0;
      tick(4);
      for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)), 4, m);
      reset_n = 1'b0;
      m_word  = '0;
      m_count = 8'd0;
      tick(2);
      chk("midreset_word_out", {32'd0, word_out}, 64'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)), 4, m);
      mosi = 1'b0;
      tick(4);
      ss = 1'b1;
      tick(12);
      chk("after_discard_word_out", {32'd0, word_out}, 64'd0);
      chk("after_discard_rx_count", {56'd0, rx_count}, 64'd0);
      run_frame(32, 128'h00000001, 5, 1'b0);
      chk("rx_count_after_reset_frame", {56'd0, rx_count}, 64'd1);

      // 255 more good frames: the 256th since reset wraps rx_count to 0
      for (int f = 0; f < 255; f++) run_frame(32, rand128(), 3, 1'b0);
      chk("rx_count_wrap", {56'd0, rx_count}, 64'd0);

      // ss rise coincident with an extra sclk rise must not count a bit
      run_frame(32, rand128(), 4, 1'b1);

      tick(20);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
